// File: rtl/cpu32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu32_pkg
// Description : Shared sizing constants for the CPU register file.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu32_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_COUNT  = 2 ** DEF_ADDR_W;
    localparam int ZERO_REG   = 0;

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Write port plus two read ports of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import cpu32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              rvalid2;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rvalid1, rdata2, rvalid2
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rvalid1, rdata2, rvalid2
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_read_port
// Description : One registered read port; optional write-through bypass
//               when REG_FILE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_read_port
    import cpu32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    input  wire logic [DATA_W-1:0] i_regs [2**ADDR_W],
`ifdef REG_FILE_BYPASS_EN
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
`endif
    output logic      [DATA_W-1:0] o_rdata,
    output logic                   o_rvalid
);

    logic [DATA_W-1:0] w_read_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

`ifdef REG_FILE_BYPASS_EN
    logic w_bypass;

    // Writes to the zero register are dropped, so they must never be forwarded.
    assign w_bypass    = i_we && (i_waddr == i_raddr) && (i_waddr != ADDR_W'(ZERO_REG));
    assign w_read_data = w_bypass ? i_wdata : i_regs[i_raddr];
`else
    assign w_read_data = i_regs[i_raddr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) begin
                r_rdata <= w_read_data;
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 2**ADDR_W x DATA_W register file, one write / two read ports,
//               register 0 hard-wired to zero. Macro REG_FILE_BYPASS_EN enables
//               same-edge write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic clk,
    input  wire logic rst_n,
    reg_file_if.slave bus
);

    localparam int c_reg_count = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_regs [c_reg_count];

    generate
        for (genvar gi = 0; gi < c_reg_count; gi++) begin : g_regs
            if (gi == ZERO_REG) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_storage
                logic [DATA_W-1:0] r_value;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_value <= '0;
                    end else if (bus.we && (bus.waddr == ADDR_W'(gi))) begin
                        r_value <= bus.wdata;
                    end
                end

                assign w_regs[gi] = r_value;
            end
        end
    endgenerate

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_re     (bus.re1),
        .i_raddr  (bus.raddr1),
        .i_regs   (w_regs),
`ifdef REG_FILE_BYPASS_EN
        .i_we     (bus.we),
        .i_waddr  (bus.waddr),
        .i_wdata  (bus.wdata),
`endif
        .o_rdata  (bus.rdata1),
        .o_rvalid (bus.rvalid1)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_re     (bus.re2),
        .i_raddr  (bus.raddr2),
        .i_regs   (w_regs),
`ifdef REG_FILE_BYPASS_EN
        .i_we     (bus.we),
        .i_waddr  (bus.waddr),
        .i_wdata  (bus.wdata),
`endif
        .o_rdata  (bus.rdata2),
        .o_rvalid (bus.rvalid2)
    );

endmodule
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; register count = 2**ADDR_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port we, input, 1, write enable, sampled at the clk rising edge.
REQ-006 The block SHALL have port waddr, input, ADDR_W, write address.
REQ-007 The block SHALL have port wdata, input, DATA_W, write data.
REQ-008 The block SHALL have port re1, input, 1, read-port-1 request.
REQ-009 The block SHALL have port raddr1, input, ADDR_W, read-port-1 address.
REQ-010 The block SHALL have port rdata1, output, DATA_W, read-port-1 data, registered.
REQ-011 The block SHALL have port rvalid1, output, 1, read-port-1 data valid, one-cycle pulse.
REQ-012 The block SHALL have ports re2, raddr2, rdata2 and rvalid2, identical in width and meaning to the port-1 ports.

Function
REQ-013 A write SHALL update register waddr with wdata at the rising edge where we=1; no other register SHALL change.
REQ-014 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-015 A read SHALL have a latency of 1: re1=1 at edge N gives rdata1=reg[raddr1] and rvalid1=1 after edge N.
REQ-016 rvalid1 SHALL be 0 after any edge where re1=0, and rdata1 SHALL hold its last value in that case.
REQ-017 Ports 1 and 2 SHALL operate independently; both ports SHALL be allowed to read the same address in the same cycle.
REQ-018 For a read and a write to the same nonzero address at the same edge, read data SHALL follow REQ-023 or REQ-024.
REQ-019 Back-to-back reads (re held high) SHALL return one result per cycle with no bubbles.
REQ-020 Address inputs SHALL be used at full width; every encoding is valid, with no wrap or overflow case.

Reset
REQ-021 rst_n=0 SHALL, asynchronously and with no dependence on clk, clear all registers, rdata1, rdata2, rvalid1 and rvalid2 to 0.
REQ-022 Writes or reads in progress when reset asserts SHALL be discarded; the first legal operation SHALL occur at the first rising edge with rst_n=1.

Configuration
REQ-023 With macro REG_FILE_BYPASS_EN defined, a same-edge read and write to the same nonzero address SHALL return the new wdata.
REQ-024 Without REG_FILE_BYPASS_EN, that read SHALL return the pre-write value; the written value SHALL be visible from the following read onward.

Structure
REQ-025 DATA_W and ADDR_W defaults, REG_COUNT and ZERO_REG SHALL live in shared package cpu32_pkg.
REQ-026 Read logic SHALL be sub-module reg_file_read_port, holding the address mux, the bypass compare, and the rdata/rvalid registers. It SHALL be instantiated twice.

Verification
REQ-027 Assert rst_n=0 mid-simulation with rdata1=0xDEADBEEF -> rdata1=0 and rvalid1=0 immediately, before any clk edge.
REQ-028 Write 0x12345678 to r5, then re1=1 with raddr1=5 -> next cycle rdata1=0x12345678 and rvalid1=1; the cycle after with re1=0 -> rvalid1=0 and rdata1 held.
REQ-029 Write 0xFFFFFFFF to r0, then read r0 on both ports -> rdata1=rdata2=0.
REQ-030 Same edge: we=1, waddr=7, wdata=0xA5A5A5A5 (old value 0x1) with re1=1, raddr1=7 -> rdata1=0xA5A5A5A5 with REG_FILE_BYPASS_EN defined, 0x00000001 without it.
REQ-031 Fill r1..r31 with value=index, then stream reads with port 1 ascending and port 2 descending -> every cycle rvalid1=rvalid2=1 with the matching indices.
